// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Four-digit multiplexed seven-segment driver. A free-running shift-add-3
//   FSM (IDLE -> CONV x13 -> LOAD) converts a 13-bit binary word to BCD
//   every 15 cycles. Only LOAD writes the display registers, so the scan
//   never shows a half-converted number. A refresh divider steps a 2-bit
//   digit index that selects which digit's anode and segments are driven.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (2 .. 2^20)
//   BLANK_LZ     1: blank leading zero digits (ones digit always shown)
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous, active-high reset
//   value  in  13   binary display word, sampled once per conversion (IDLE)
//   anode  out  4   active-low digit enables, [0] = ones, [3] = thousands
//   seg    out  7   active-low segments {g,f,e,d,c,b,a}
//   upd    out  1   one-cycle pulse while LOAD copies the new BCD digits
module ssd_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        upd
);

    localparam int unsigned    RW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0]  R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [3:0]     N_BITS = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Conversion FSM state
    // ------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic [12:0]       r_bin,   w_bin_nxt;
    logic [15:0]       r_bcd,   w_bcd_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;
    logic [3:0][3:0]   r_disp,  w_disp_nxt;
    logic              r_upd,   w_upd_nxt;

    // Add-3 correction on every nibble >= 5, then the whole {bcd, bin}
    // word shifts left one place. Bit 15 of the corrected BCD falls off;
    // for inputs up to 8191 it is always zero.
    logic [15:0]       w_adj;
    logic [28:0]       w_sh;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3
                                                         : r_bcd[i*4 +: 4];
        end
    end

    assign w_sh = {w_adj, r_bin} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_upd   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_disp  <= w_disp_nxt;
            r_upd   <= w_upd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_bcd_nxt   = r_bcd;
        w_cnt_nxt   = r_cnt;
        w_disp_nxt  = r_disp;
        w_upd_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bin_nxt   = value;
                w_bcd_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_CONV;
            end
            S_CONV: begin
                w_bcd_nxt = w_sh[28:13];
                w_bin_nxt = w_sh[12:0];
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == N_BITS - 4'd1) begin
                    w_state_nxt = S_LOAD;
                    // upd is registered, so raising it on entry makes it
                    // high for exactly the LOAD cycle.
                    w_upd_nxt   = 1'b1;
                end
            end
            S_LOAD: begin
                w_disp_nxt  = r_bcd;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Refresh divider and digit index
    // ------------------------------------------------------------------
    logic [RW-1:0] r_ref;
    logic [1:0]    r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == R_LAST) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ref <= r_ref + RW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit select, leading-zero blanking, segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic       w_blank;
    logic [3:0] w_digit;
    logic [6:0] w_seg_nxt;
    logic [3:0] w_anode_nxt;

    // A digit is a leading zero when it and every higher digit are zero.
    // The ones digit is never blanked so zero still shows as "0".
    always_comb begin
        w_blank = 1'b0;
        if (BLANK_LZ) begin
            case (r_idx)
                2'd1:    w_blank = (r_disp[3:1] == 12'd0);
                2'd2:    w_blank = (r_disp[3:2] == 8'd0);
                2'd3:    w_blank = (r_disp[3]   == 4'd0);
                default: w_blank = 1'b0;
            endcase
        end
    end

    assign w_digit     = r_disp[r_idx];
    assign w_seg_nxt   = w_blank ? 7'h7F : seg_decode(w_digit);
    assign w_anode_nxt = ~(4'b0001 << r_idx);

    logic [3:0] r_anode;
    logic [6:0] r_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode <= 4'b1110;
            r_seg   <= 7'h40;
        end else begin
            r_anode <= w_anode_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign anode = r_anode;
    assign seg   = r_seg;
    assign upd   = r_upd;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver
//   Two instances share clk/rst/value: one with REFRESH_DIV=2, BLANK_LZ=1,
//   one with REFRESH_DIV=3, BLANK_LZ=0. A model process tracks the cycle
//   count since reset and queues every sampled value; a monitor pops the
//   queue on each upd pulse and checks anode/seg/upd of both instances on
//   every cycle against plain decimal arithmetic.
module tb_ssd_scan_driver;

    localparam int DIV0 = 2;
    localparam int DIV1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] value = 13'd0;
    logic [3:0]  anode0, anode1;
    logic [6:0]  seg0, seg1;
    logic        upd0, upd1;

    ssd_scan_driver #(.REFRESH_DIV(DIV0), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode0), .seg(seg0), .upd(upd0)
    );

    ssd_scan_driver #(.REFRESH_DIV(DIV1), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode1), .seg(seg1), .upd(upd1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- reference helpers ----------------
    function automatic int dig(input int v, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
            4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
            8: return 'h00;  9: return 'h10;
            default: return 'h7F;
        endcase
    endfunction

    // Displayed number v, digit slot i: a leading zero is any slot whose
    // place value exceeds v (slot 0 excepted).
    function automatic int exp_seg(input int v, input int i, input bit blz);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (blz && i > 0 && v < p) return 'h7F;
        return seg_of(dig(v, i));
    endfunction

    function automatic int exp_anode(input int i);
        return 'hF & ~(1 << i);
    endfunction

    // ---------------- model: cycle count + sampled values ----------------
    int ph       = 0;   // index of current cycle since the last reset edge
    bit rst_seen = 1'b1;
    int q[$];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            ph = 0;
            rst_seen = 1'b1;
            q.delete();
        end else begin
            rst_seen = 1'b0;
            if (ph % 15 == 0) q.push_back(int'(value));
            ph++;
        end
    end

    // ---------------- monitor ----------------
    int pval     = 0;   // number shown during the previous cycle
    int pend     = 0;
    bit upd_prev = 1'b0;
    int pidx0    = 0;
    int pidx1    = 0;

    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            chk("rst_anode0", int'(anode0), 'hE);
            chk("rst_seg0",   int'(seg0),   'h40);
            chk("rst_upd0",   int'(upd0),   0);
            chk("rst_anode1", int'(anode1), 'hE);
            chk("rst_seg1",   int'(seg1),   'h40);
            chk("rst_upd1",   int'(upd1),   0);
            pval = 0; pidx0 = 0; pidx1 = 0; upd_prev = 1'b0;
        end else begin
            chk("anode0", int'(anode0), exp_anode(pidx0));
            chk("seg0",   int'(seg0),   exp_seg(pval, pidx0, 1'b1));
            chk("anode1", int'(anode1), exp_anode(pidx1));
            chk("seg1",   int'(seg1),   exp_seg(pval, pidx1, 1'b0));
            chk("upd0",   int'(upd0),   int'(ph % 15 == 14));
            chk("upd1",   int'(upd1),   int'(ph % 15 == 14));
            if (upd_prev) pval = pend;
            pidx0 = (ph / DIV0) % 4;
            pidx1 = (ph / DIV1) % 4;
            if (upd0) begin
                if (q.size() == 0) chk("upd_without_sample", 1, 0);
                else pend = q.pop_front();
            end
            upd_prev = upd0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ph(input int k);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (ph % 15 == k) hit = 1'b1;
        end
        chk("wait_phase", int'(hit), 1);
    endtask

    initial begin
        rst = 1'b1;
        value = 13'd1234;
        hold(2);
        rst = 1'b0;
        hold(45);
        value = 13'd8191;  hold(45);
        value = 13'd7;     hold(45);
        value = 13'd0;     hold(45);
        value = 13'd1234;  hold(16);
        wait_ph(5);
        value = 13'd5678;  hold(45);
        value = 13'd4095;  hold(16);
        wait_ph(8);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        hold(45);
        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) value = 13'($urandom_range(0, 8191));
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        value = 13'd8191;
        hold(50);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
